// File: rtl/sram_buffer_pkg.sv
// Shared types for the SRAM load buffer: FSM states, reload modes and the
// mode-to-first-state decode.
package sram_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_IMG,
    LOAD_WT,
    DONE
  } load_state_t;

  typedef enum logic [1:0] {
    LM_BOTH,
    LM_IMG,
    LM_WT,
    LM_RSVD
  } load_mode_t;

  // The reserved mode behaves like LM_BOTH, so only LM_WT skips the image pass.
  function automatic load_state_t first_state(load_mode_t mode);
    return (mode == LM_WT) ? LOAD_WT : LOAD_IMG;
  endfunction

endpackage

// File: rtl/sram_load_buffer_if.sv
// Word-read channel between the load buffer (master) and the SRAM controller (slave).
interface sram_load_buffer_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned BUS_W  = 32
) ();

  logic              sram_req;
  logic [ADDR_W-1:0] sram_addr;
  logic [BUS_W-1:0]  sram_data;
  logic              sram_done;

  modport master (
    output sram_req,
    output sram_addr,
    input  sram_data,
    input  sram_done
  );

  modport slave (
    input  sram_req,
    input  sram_addr,
    output sram_data,
    output sram_done
  );

endinterface

// File: rtl/sram_load_buffer.sv
// Fetches SRAM words and unpacks them into the image and weight register banks,
// with selective reload so the weights can persist across images.
module sram_load_buffer
  import sram_buffer_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned BUS_W     = 32,
  parameter int unsigned IMG_DEPTH = 64,
  parameter int unsigned WT_DEPTH  = 1024,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned IMG_BASE  = 0,
  parameter int unsigned WT_BASE   = 32
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start_sram,
  input  logic [1:0]           load_mode,
  sram_load_buffer_if.master   sram,
  output logic                 buffer_ready,
  output logic                 busy,
  output logic [DATA_W-1:0]    image   [IMG_DEPTH],
  output logic [DATA_W-1:0]    weights [WT_DEPTH]
);

  localparam int unsigned EPW       = BUS_W / DATA_W;
  localparam int unsigned IMG_WORDS = IMG_DEPTH / EPW;
  localparam int unsigned WT_WORDS  = WT_DEPTH / EPW;
  localparam int unsigned MAX_WORDS = (IMG_WORDS > WT_WORDS) ? IMG_WORDS : WT_WORDS;
  localparam int unsigned CNT_W     = $clog2(MAX_WORDS) + 1;

  load_state_t       state_q, state_d;
  load_mode_t        mode_q, mode_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic img_last;
  logic wt_last;

  assign img_last = (cnt_q == CNT_W'(IMG_WORDS - 1));
  assign wt_last  = (cnt_q == CNT_W'(WT_WORDS - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      mode_q  <= LM_BOTH;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_sram) begin
          mode_d  = load_mode_t'(load_mode);
          state_d = first_state(mode_d);
          cnt_d   = '0;
          addr_d  = (mode_d == LM_WT) ? ADDR_W'(WT_BASE) : ADDR_W'(IMG_BASE);
        end
      end
      LOAD_IMG: begin
        if (sram.sram_done) begin
          addr_d = addr_q + ADDR_W'(1);
          cnt_d  = cnt_q + CNT_W'(1);
          if (img_last) begin
            cnt_d = '0;
            if (mode_q == LM_IMG) begin
              state_d = DONE;
            end else begin
              state_d = LOAD_WT;
              addr_d  = ADDR_W'(WT_BASE);
            end
          end
        end
      end
      LOAD_WT: begin
        if (sram.sram_done) begin
          addr_d = addr_q + ADDR_W'(1);
          cnt_d  = cnt_q + CNT_W'(1);
          if (wt_last) begin
            cnt_d   = '0;
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy           = (state_q == LOAD_IMG) || (state_q == LOAD_WT);
  assign buffer_ready   = (state_q == DONE);
  assign sram.sram_req  = busy;
  assign sram.sram_addr = addr_q;

  // Element e lives in word e/EPW, lane e%EPW; lane 0 is the low slice of the word.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      image <= '{default: '0};
    end else if (state_q == LOAD_IMG && sram.sram_done) begin
      for (int e = 0; e < IMG_DEPTH; e++) begin
        if (cnt_q == CNT_W'(e / EPW)) begin
          image[e] <= sram.sram_data[(e % EPW)*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      weights <= '{default: '0};
    end else if (state_q == LOAD_WT && sram.sram_done) begin
      for (int e = 0; e < WT_DEPTH; e++) begin
        if (cnt_q == CNT_W'(e / EPW)) begin
          weights[e] <= sram.sram_data[(e % EPW)*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_load_buffer.sv
// Directed bench for sram_load_buffer: a table of load requests plus hand-written
// reset, idle-strobe and done-strobe sequences.
module tb_sram_load_buffer;
  import sram_buffer_pkg::*;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned BUS_W     = 32;
  localparam int unsigned IMG_DEPTH = 64;
  localparam int unsigned WT_DEPTH  = 1024;
  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned IMG_BASE  = 0;
  localparam int unsigned WT_BASE   = 32;
  localparam int          BUDGET    = 4000;

  logic              clk;
  logic              n_rst;
  logic              start_sram;
  logic [1:0]        load_mode;
  logic              buffer_ready;
  logic              busy;
  logic [DATA_W-1:0] image   [IMG_DEPTH];
  logic [DATA_W-1:0] weights [WT_DEPTH];

  int off;
  int n_checks;
  int n_fail;

  sram_load_buffer_if #(.ADDR_W(ADDR_W), .BUS_W(BUS_W)) sram_bus ();

  sram_load_buffer #(
    .DATA_W   (DATA_W),
    .BUS_W    (BUS_W),
    .IMG_DEPTH(IMG_DEPTH),
    .WT_DEPTH (WT_DEPTH),
    .ADDR_W   (ADDR_W),
    .IMG_BASE (IMG_BASE),
    .WT_BASE  (WT_BASE)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .start_sram  (start_sram),
    .load_mode   (load_mode),
    .sram        (sram_bus),
    .buffer_ready(buffer_ready),
    .busy        (busy),
    .image       (image),
    .weights     (weights)
  );

  // SRAM model: word at address a holds {2a+1+off, 2a+off}.
  always_comb begin
    sram_bus.sram_data = {16'(2 * int'(sram_bus.sram_addr) + 1 + off),
                          16'(2 * int'(sram_bus.sram_addr) + off)};
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  typedef struct {
    logic [1:0] mode;
    int         off;
    int         img_off;
    int         wt_off;
    int         edges;   // 0: not checked (random strobe gaps)
    int         words;
    bit         gaps;
    bit         pulse;
  } load_vec_t;

  load_vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_banks(input string tag, input int img_off, input int wt_off,
                             input bit zero);
    int bad;
    int fi;
    int fa;
    int fe;
    int e;
    bad = 0;
    fi  = -1;
    fa  = 0;
    fe  = 0;
    for (int i = 0; i < IMG_DEPTH; i++) begin
      e = zero ? 0 : ((i + 2 * IMG_BASE + img_off) & 'hFFFF);
      if (int'(image[i]) != e) begin
        if (fi < 0) begin
          fi = i;
          fa = int'(image[i]);
          fe = e;
        end
        bad++;
      end
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s_image: %0d bad, image[%0d] got %0d, expected %0d",
               tag, bad, fi, fa, fe);
    end
    bad = 0;
    fi  = -1;
    for (int j = 0; j < WT_DEPTH; j++) begin
      e = zero ? 0 : ((j + 2 * WT_BASE + wt_off) & 'hFFFF);
      if (int'(weights[j]) != e) begin
        if (fi < 0) begin
          fi = j;
          fa = int'(weights[j]);
          fe = e;
        end
        bad++;
      end
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s_weights: %0d bad, weights[%0d] got %0d, expected %0d",
               tag, bad, fi, fa, fe);
    end
  endtask

  function automatic int exp_addr(input logic [1:0] mode, input int s);
    if (mode == 2'b10) return WT_BASE + s;
    if (s < IMG_DEPTH / 2) return IMG_BASE + s;
    return WT_BASE + s - IMG_DEPTH / 2;
  endfunction

  // Edge count includes the edge that samples start_sram.
  task automatic run_load(input load_vec_t v, input int idx);
    string tag;
    int    edges;
    int    s;
    int    addr_bad;
    bit    d;
    tag = $sformatf("load%0d", idx);
    off = v.off;
    load_mode = v.mode;
    start_sram = 1'b1;
    sram_bus.sram_done = 1'b1;
    @(posedge clk);
    #1;
    start_sram = 1'b0;
    edges = 1;
    s = 0;
    addr_bad = 0;
    check({tag, "_busy_after_start"}, int'(busy), 1);
    check({tag, "_ready_after_start"}, int'(buffer_ready), 0);
    while (!buffer_ready && edges < BUDGET) begin
      d = v.gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      sram_bus.sram_done = d;
      if (v.pulse && edges == 100) begin
        start_sram = 1'b1;
        load_mode = 2'b01;
      end
      @(posedge clk);
      #1;
      start_sram = 1'b0;
      edges++;
      if (d) s++;
      if (busy && int'(sram_bus.sram_addr) != exp_addr(v.mode, s)) addr_bad++;
    end
    sram_bus.sram_done = 1'b0;
    check({tag, "_ready"}, int'(buffer_ready), 1);
    check({tag, "_busy_done"}, int'(busy), 0);
    check({tag, "_req_done"}, int'(sram_bus.sram_req), 0);
    if (v.edges != 0) check({tag, "_edges"}, edges, v.edges);
    check({tag, "_words"}, s, v.words);
    check({tag, "_addr_track_errors"}, addr_bad, 0);
    check_banks(tag, v.img_off, v.wt_off, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    off = 0;
    n_rst = 1'b0;
    start_sram = 1'b0;
    load_mode = 2'b00;
    sram_bus.sram_done = 1'b0;

    //                mode   off   img   wt    edges words gaps pulse
    vecs[0] = '{2'b00, 0,    0,    0,    545,  544,  0,   0};
    vecs[1] = '{2'b01, 1000, 1000, 0,    33,   32,   0,   0};
    vecs[2] = '{2'b10, 5000, 1000, 5000, 0,    512,  1,   0};
    vecs[3] = '{2'b00, 0,    0,    0,    545,  544,  0,   1};
    vecs[4] = '{2'b11, 7,    7,    7,    545,  544,  0,   0};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_ready", int'(buffer_ready), 0);
    check("reset_req", int'(sram_bus.sram_req), 0);
    check("reset_addr", int'(sram_bus.sram_addr), 0);
    check_banks("reset", 0, 0, 1'b1);
    n_rst = 1'b1;

    // Strobes in IDLE are ignored.
    off = 123;
    sram_bus.sram_done = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    sram_bus.sram_done = 1'b0;
    check("idle_strobe_addr", int'(sram_bus.sram_addr), 0);
    check("idle_strobe_busy", int'(busy), 0);
    check_banks("idle_strobe", 0, 0, 1'b1);

    for (int k = 0; k < 5; k++) begin
      run_load(vecs[k], k);
      @(posedge clk);
      #1;
    end

    // Strobes in DONE: no writes, address holds at WT_BASE + 512.
    off = 9999;
    sram_bus.sram_done = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    sram_bus.sram_done = 1'b0;
    check("done_strobe_addr", int'(sram_bus.sram_addr), 544);
    check("done_strobe_ready", int'(buffer_ready), 1);
    check_banks("done_strobe", 7, 7, 1'b0);

    // Asynchronous reset in the middle of a load.
    off = 0;
    load_mode = 2'b00;
    start_sram = 1'b1;
    sram_bus.sram_done = 1'b1;
    @(posedge clk);
    #1;
    start_sram = 1'b0;
    repeat (100) @(posedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    check("midreset_state", int'(dut.state_q), int'(IDLE));
    check("midreset_busy", int'(busy), 0);
    check("midreset_ready", int'(buffer_ready), 0);
    check("midreset_req", int'(sram_bus.sram_req), 0);
    check("midreset_addr", int'(sram_bus.sram_addr), 0);
    check_banks("midreset", 0, 0, 1'b1);
    sram_bus.sram_done = 1'b0;
    @(posedge clk);
    #1;
    n_rst = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
